// File: rtl/branch_predictor_if.sv
// Fetch/EX-facing port bundle of the branch predictor.
//   pc_f          fetch PC (driven by fetch)
//   pred_taken    direction prediction for pc_f (driven by predictor)
//   pc_pred       predicted target for pc_f, 0 when not predicted taken
//   update_en     EX has a resolved branch/jump this cycle
//   update_pc     PC of the resolved instruction
//   update_taken  resolved direction
//   update_target resolved taken target
//   update_uncond resolved op is JAL/JALR
// Handshake: there is no valid/ready pair. The lookup is a pure
// combinational function of pc_f; an update is a one-cycle command that is
// consumed on the rising clk edge where update_en=1, with no back-pressure.
interface branch_predictor_if;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pc_pred;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_uncond;

  modport master (
    output pc_f, update_en, update_pc, update_taken, update_target, update_uncond,
    input  pred_taken, pc_pred
  );

  modport slave (
    input  pc_f, update_en, update_pc, update_taken, update_target, update_uncond,
    output pred_taken, pc_pred
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: a direct-mapped BTB with a 2-bit saturating
// direction counter per entry.
//   clk    core clock
//   rst_n  asynchronous active-low reset; clears every entry
//   bp     branch_predictor_if.slave: combinational lookup on pc_f
//          (pred_taken, pc_pred) and the EX-stage training port (update_*)
// A lookup and an update of the same entry in one cycle read the old
// contents; the written value shows up from the next cycle.
module branch_predictor #(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input logic              clk,
  input logic              rst_n,
  branch_predictor_if.slave bp
);

  // Per-entry storage, all in flops so the async reset clears the table.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;

  assign look_idx      = bp.pc_f[IDX_W+1:2];
  assign look_tag      = bp.pc_f[31:IDX_W+2];
  assign look_hit      = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign bp.pred_taken = look_hit && ctr_q[look_idx][1];
  assign bp.pc_pred    = bp.pred_taken ? target_q[look_idx] : 32'b0;

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_match;
  logic             upd_taken_eff;
  logic [1:0]       cur_ctr;

  logic             wr_en;
  logic [TAG_W-1:0] nxt_tag;
  logic [31:0]      nxt_target;
  logic [1:0]       nxt_ctr;

  assign upd_idx   = bp.update_pc[IDX_W+1:2];
  assign upd_tag   = bp.update_pc[31:IDX_W+2];
  assign upd_match = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign cur_ctr   = ctr_q[upd_idx];
  // An unconditional op is always taken, even if update_taken was left low.
  assign upd_taken_eff = bp.update_taken || bp.update_uncond;

  always_comb begin
    wr_en      = 1'b0;
    nxt_tag    = tag_q[upd_idx];
    nxt_target = target_q[upd_idx];
    nxt_ctr    = cur_ctr;
    if (bp.update_en) begin
      if (upd_match) begin
        wr_en = 1'b1;
        if (bp.update_uncond) begin
          nxt_ctr    = 2'b11;
          nxt_target = bp.update_target;
        end else if (bp.update_taken) begin
          nxt_ctr    = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
          nxt_target = bp.update_target;
        end else begin
          nxt_ctr    = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
        end
      end else if (upd_taken_eff) begin
        // Taken miss: allocate, replacing whatever occupied the slot.
        // Not-taken misses leave the table alone.
        wr_en      = 1'b1;
        nxt_tag    = upd_tag;
        nxt_target = bp.update_target;
        nxt_ctr    = bp.update_uncond ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= nxt_tag;
      target_q[upd_idx] <= nxt_target;
      ctr_q[upd_idx]    <= nxt_ctr;
    end
  end

  // Instruction PCs are word aligned; the low bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pc_f[1:0], bp.update_pc[1:0]};

  // A not-taken JAL/JALR is not a legal outcome from EX.
  a_uncond_is_taken : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bp.update_en && bp.update_uncond && !bp.update_taken)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. A driver task applies one cycle of
// stimulus and queues the expected lookup result; a monitor on the falling
// edge pops and compares whenever a lookup check is flagged.
module tb_branch_predictor;

  logic clk;
  logic rst_n;
  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  // ------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------- scoreboard
  logic [32:0] exp_q[$];
  logic        chk_valid;
  int          checks;
  int          errors;

  always @(negedge clk) begin
    if (chk_valid) begin
      logic [32:0] exp_v;
      logic [32:0] act_v;
      checks++;
      act_v = {bp.pred_taken, bp.pc_pred};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL lookup pc=%08h: no expected entry, got taken=%0b target=%08h",
                 bp.pc_f, act_v[32], act_v[31:0]);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL lookup pc=%08h: got taken=%0b target=%08h, want taken=%0b target=%08h",
                   bp.pc_f, act_v[32], act_v[31:0], exp_v[32], exp_v[31:0]);
        end
      end
    end
  end

  // ------------------------------------------------------- driver tasks
  task automatic step(input logic [31:0] pc, input logic chk, input logic exp_t,
                      input logic [31:0] exp_pc, input logic ue, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic uu);
    @(posedge clk);
    #1;
    bp.pc_f          = pc;
    bp.update_en     = ue;
    bp.update_pc     = upc;
    bp.update_taken  = ut;
    bp.update_target = utgt;
    bp.update_uncond = uu;
    chk_valid        = chk;
    if (chk) exp_q.push_back({exp_t, exp_pc});
  endtask

  task automatic look(input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_pc);
    step(pc, 1'b1, exp_t, exp_pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic u);
    step(32'hFFFF_FFF0, 1'b0, 1'b0, 32'h0, 1'b1, pc, t, tgt, u);
  endtask

  // Reset asserted in the middle of a cycle that also carries an update.
  task automatic mid_cycle_reset();
    @(posedge clk);
    #1;
    chk_valid        = 1'b0;
    bp.pc_f          = 32'h300;
    bp.update_en     = 1'b1;
    bp.update_pc     = 32'h500;
    bp.update_taken  = 1'b1;
    bp.update_target = 32'h900;
    bp.update_uncond = 1'b0;
    #1;
    checks++;
    if ({bp.pred_taken, bp.pc_pred} !== {1'b1, 32'h380}) begin
      errors++;
      $display("FAIL pre_reset pc=00000300: got taken=%0b target=%08h, want taken=1 target=00000380",
               bp.pred_taken, bp.pc_pred);
    end
    rst_n = 1'b0;
    exp_q.push_back({1'b0, 32'h0});
    chk_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_valid    = 1'b0;
    bp.update_en = 1'b0;
    rst_n        = 1'b1;
  endtask

  // ------------------------------------------------------- stimulus
  initial begin
    rst_n            = 1'b0;
    chk_valid        = 1'b0;
    checks           = 0;
    errors           = 0;
    bp.pc_f          = 32'h0;
    bp.update_en     = 1'b0;
    bp.update_pc     = 32'h0;
    bp.update_taken  = 1'b0;
    bp.update_target = 32'h0;
    bp.update_uncond = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: empty table predicts nothing anywhere in the first 64 words.
    for (int a = 0; a < 'h100; a += 4) look(a, 1'b0, 32'h0);

    // 2: conditional taken allocation -> ctr=10, predicted next cycle.
    train(32'h100, 1'b1, 32'h200, 1'b0);
    look(32'h100, 1'b1, 32'h200);

    // 3: decrement to 00 and hold there.
    train(32'h100, 1'b0, 32'h0, 1'b0);   // 10 -> 01
    look(32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b0, 32'h0, 1'b0);   // 01 -> 00
    look(32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b0, 32'h0, 1'b0);   // stays 00
    train(32'h100, 1'b1, 32'h240, 1'b0); // 00 -> 01 (a wrap to 11 would give 11)
    look(32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h260, 1'b0); // 01 -> 10
    look(32'h100, 1'b1, 32'h260);

    // Not-taken miss must not allocate.
    train(32'h108, 1'b0, 32'h700, 1'b0);
    look(32'h108, 1'b0, 32'h0);

    // Unconditional allocation -> ctr=11: needs two not-taken to stop predicting.
    train(32'h104, 1'b1, 32'h800, 1'b1);
    look(32'h104, 1'b1, 32'h800);
    train(32'h104, 1'b0, 32'h0, 1'b0);   // 11 -> 10
    look(32'h104, 1'b1, 32'h800);
    train(32'h104, 1'b0, 32'h0, 1'b0);   // 10 -> 01
    look(32'h104, 1'b0, 32'h0);
    // Unconditional hit forces 11 and retargets.
    train(32'h104, 1'b1, 32'h880, 1'b1);
    look(32'h104, 1'b1, 32'h880);

    // 4: alias 0x100 + 4*64 = 0x200 replaces index 0.
    train(32'h200, 1'b1, 32'h400, 1'b0);
    look(32'h100, 1'b0, 32'h0);
    look(32'h200, 1'b1, 32'h400);
    look(32'h104, 1'b1, 32'h880);        // neighbour undisturbed

    // 5: same-cycle lookup and update read the old contents.
    step(32'h300, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h380, 1'b0);
    look(32'h300, 1'b1, 32'h380);
    look(32'h200, 1'b0, 32'h0);          // evicted by 0x300 (same index)

    // 6: asynchronous reset mid-cycle, pending update discarded.
    mid_cycle_reset();
    look(32'h300, 1'b0, 32'h0);
    look(32'h500, 1'b0, 32'h0);
    look(32'h104, 1'b0, 32'h0);
    look(32'h100, 1'b0, 32'h0);

    step(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected lookups never checked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
